fifo_flags: RTL
===============

Name: fifo_flags

Overview:
- Parametrised synchronous FIFO: circular-queue register file plus control, with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Successor to the basic UART-path FIFO. Drop-in for UART RX/TX buffering where flow control needs early warning and error visibility.
- Read data is first-word-fall-through: the head entry is always visible on o_r_data.

Parameters:
- B, 8, data word width in bits.
- W, 4, address bits; depth = 2**W entries.
- AF_TH, 2**W-2, almost-full threshold; o_almost_full when count >= AF_TH; legal range 1..2**W.
- AE_TH, 1, almost-empty threshold; o_almost_empty when count <= AE_TH; legal range 0..2**W-1.

Ports:
- clock, input, 1, rising-edge clock.
- i_reset, input, 1, reset, asynchronous, active-high.
- i_wr, input, 1, write request.
- i_rd, input, 1, read request (pops the head).
- i_w_data, input, B, write data.
- i_clr_err, input, 1, synchronous clear of sticky flags (and of the watermark when enabled).
- o_r_data, output, B, head entry, combinational from the array.
- o_empty, output, 1, count == 0.
- o_full, output, 1, count == 2**W.
- o_almost_empty, output, 1, count <= AE_TH.
- o_almost_full, output, 1, count >= AF_TH.
- o_count, output, W+1, occupancy 0..2**W.
- o_overflow, output, 1, sticky: write attempted while full and not accepted.
- o_underflow, output, 1, sticky: read attempted while empty.
- o_max_count, output, W+1, peak occupancy (optional feature).

Behaviour:
- Reset (async, i_reset=1):
  - w_ptr=0, r_ptr=0, count=0.
  - o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=(AF_TH==0 ? 1 : 0), effectively 0 for legal AF_TH.
  - o_overflow=0, o_underflow=0, o_max_count=0.
  - Array contents are not reset. o_r_data is undefined while empty.
- Reset mid-operation: all state returns to reset values immediately. A pending write in that cycle is discarded.
- Request qualification:
  - wr_ok = i_wr & (~full | i_rd).
  - rd_ok = i_rd & ~empty.
- Per cycle:
  - wr_ok: array[w_ptr] <= i_w_data; w_ptr <= w_ptr+1, wrapping mod 2**W.
  - rd_ok: r_ptr <= r_ptr+1, wrapping.
  - count_next = count + wr_ok - rd_ok.
- Simultaneous events:
  - Empty with rd+wr: write accepted, read ignored, underflow set, count 0->1.
  - Full with rd+wr: both accepted, count stays 2**W, o_full stays 1, no overflow.
  - Partially full with rd+wr: both accepted, count unchanged.
- Write while full without read: data dropped, pointers unchanged, o_overflow set on the next edge.
- All status flags are registers derived from count_next, so they are valid in the same cycle as o_count (one edge after the causing request).
- Sticky flags:
  - Set by the error event; cleared only by reset or i_clr_err.
  - i_clr_err in the same cycle as a new error event: set wins.
- Latency:
  - Write-to-visible (empty FIFO): o_r_data shows the new word and o_empty falls one edge after the write.
  - Read: the next head appears one edge after rd_ok.
- No state machine beyond the pointer/count registers. Count is the single source of truth for full/empty; no pointer-equality ambiguity.

Optional Feature:
- Macro FIFO_FLAGS_WATERMARK_EN.
- Defined: o_max_count is a register; o_max_count <= max(o_max_count, count_next) each edge; i_clr_err loads count_next.
- Undefined: o_max_count is tied to 0 and no register is inferred.

Decomposition:
- Shared header fifo_defs.vh:
  - FIFO_DEF_B and FIFO_DEF_W default constants.
  - A localparam helper for DEPTH = 2**W.
  - A macro for the count width W+1.
- One sub-module fifo_regfile:
  - Parameters B, W.
  - Synchronous write port (clock, we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - fifo_flags holds only control, pointers, count and flags.

Test Plan (B=8, W=2 → depth 4, AF_TH=3, AE_TH=1):
- Reset, then write 0x11,0x22,0x33 on 3 edges → o_count=3, o_almost_full=1, o_almost_empty=0, o_r_data=0x11.
- Write 0x44 → o_full=1, o_count=4. Write 0x55 alone → o_overflow=1, count stays 4. Read 4 times → data 0x11,0x22,0x33,0x44 in order, then o_empty=1.
- Full FIFO with simultaneous rd+wr of 0x66 → o_count=4, o_full=1, no overflow. Next four reads return 0x22,0x33,0x44,0x66.
- Empty FIFO with rd+wr of 0xA5 → o_count=1, o_r_data=0xA5, o_underflow=1. Pulse i_clr_err → o_underflow=0.
- Wrap-around: 10 alternating single writes/reads of 0x00..0x09 → every read matches, o_count toggles 1/0, pointers wrap with no flag errors.
- Assert i_reset asynchronously mid-write with count=2 → all flags and count return to reset values immediately, before the next clock edge. With FIFO_FLAGS_WATERMARK_EN, o_max_count=0 after reset and 4 after refilling.

Source files
------------

// File: rtl/fifo_flags_pkg.sv
// Shared definitions for the fifo_flags FIFO.
//   FIFO_DEF_B / FIFO_DEF_W : default word width and address width.
//   fifo_depth(w)           : number of entries for a w-bit address.
//   fifo_cnt_w(w)           : width of an occupancy count (0..depth inclusive).
package fifo_flags_pkg;

   localparam int unsigned FIFO_DEF_B = 8;
   localparam int unsigned FIFO_DEF_W = 4;

   function automatic int unsigned fifo_depth(input int unsigned w);
      return 32'd1 << w;
   endfunction

   // One extra bit so a completely full FIFO is distinguishable from empty.
   function automatic int unsigned fifo_cnt_w(input int unsigned w);
      return w + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_flags_regfile.sv
// Storage array for fifo_flags: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_flags_regfile
   import fifo_flags_pkg::*;
#(
   parameter int unsigned B = FIFO_DEF_B,
   parameter int unsigned W = FIFO_DEF_W
) (
   input  logic         clock,
   input  logic         we,
   input  logic [W-1:0] waddr,
   input  logic [B-1:0] wdata,
   input  logic [W-1:0] raddr,
   output logic [B-1:0] rdata
);

   localparam int unsigned Depth = fifo_depth(W);

   logic [B-1:0] mem_q [Depth];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional peak-occupancy watermark enabled by defining FIFO_FLAGS_WATERMARK_EN;
// without it o_max_count is tied to zero.
//   clock, i_reset   : rising-edge clock, asynchronous active-high reset
//   i_wr, i_w_data   : write request and data
//   i_rd             : read request, pops the head entry
//   i_clr_err        : synchronous clear of sticky flags and watermark
//   o_r_data         : head entry (undefined while empty)
//   o_empty, o_full  : count == 0 / count == depth
//   o_almost_empty   : count <= AE_TH
//   o_almost_full    : count >= AF_TH
//   o_count          : occupancy 0..depth
//   o_overflow       : sticky, write refused because full
//   o_underflow      : sticky, read attempted while empty
//   o_max_count      : peak occupancy since reset / last clear
module fifo_flags
   import fifo_flags_pkg::*;
#(
   parameter int unsigned B     = FIFO_DEF_B,
   parameter int unsigned W     = FIFO_DEF_W,
   parameter int unsigned AF_TH = fifo_depth(W) - 2,
   parameter int unsigned AE_TH = 1
) (
   input  logic         clock,
   input  logic         i_reset,
   input  logic         i_wr,
   input  logic         i_rd,
   input  logic [B-1:0] i_w_data,
   input  logic         i_clr_err,
   output logic [B-1:0] o_r_data,
   output logic         o_empty,
   output logic         o_full,
   output logic         o_almost_empty,
   output logic         o_almost_full,
   output logic [W:0]   o_count,
   output logic         o_overflow,
   output logic         o_underflow,
   output logic [W:0]   o_max_count
);

   localparam int unsigned CW    = fifo_cnt_w(W);
   localparam logic [W:0]  Depth = CW'(fifo_depth(W));
   localparam logic [W:0]  AfTh  = CW'(AF_TH);
   localparam logic [W:0]  AeTh  = CW'(AE_TH);

   logic [W-1:0] w_ptr_q, w_ptr_d;
   logic [W-1:0] r_ptr_q, r_ptr_d;
   logic [W:0]   count_q, count_d;
   logic         empty_q, full_q, a_empty_q, a_full_q;
   logic         ovf_q, ovf_d, unf_q, unf_d;
   logic         wr_ok, rd_ok;
   logic         we;

   // A read in the same cycle frees a slot, so a full FIFO still accepts.
   assign wr_ok = i_wr & (~full_q | i_rd);
   assign rd_ok = i_rd & ~empty_q;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
      // Set wins over a simultaneous clear.
      ovf_d = (i_wr & full_q & ~i_rd) | (ovf_q & ~i_clr_err);
      unf_d = (i_rd & empty_q) | (unf_q & ~i_clr_err);
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         w_ptr_q   <= '0;
         r_ptr_q   <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         a_empty_q <= 1'b1;
         a_full_q  <= (AfTh == '0);
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         w_ptr_q   <= w_ptr_d;
         r_ptr_q   <= r_ptr_d;
         count_q   <= count_d;
         empty_q   <= (count_d == '0);
         full_q    <= (count_d == Depth);
         a_empty_q <= (count_d <= AeTh);
         a_full_q  <= (count_d >= AfTh);
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

`ifdef FIFO_FLAGS_WATERMARK_EN
   logic [W:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (i_clr_err) begin
         max_d = count_d;
      end else if (count_d > max_q) begin
         max_d = count_d;
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) max_q <= '0;
      else         max_q <= max_d;
   end

   assign o_max_count = max_q;
`else
   assign o_max_count = '0;
`endif

   // Gate the write while reset is held so a write pending at reset is dropped.
   assign we = wr_ok & ~i_reset;

   fifo_flags_regfile #(
      .B (B),
      .W (W)
   ) u_regfile (
      .clock (clock),
      .we    (we),
      .waddr (w_ptr_q),
      .wdata (i_w_data),
      .raddr (r_ptr_q),
      .rdata (o_r_data)
   );

   assign o_empty        = empty_q;
   assign o_full         = full_q;
   assign o_almost_empty = a_empty_q;
   assign o_almost_full  = a_full_q;
   assign o_count        = count_q;
   assign o_overflow     = ovf_q;
   assign o_underflow    = unf_q;

endmodule
